// File: rtl/hevc_coeff_pkg.sv
// Shared constants for the serial interpolation-coefficient emitter:
// luma/chroma tap tables, tap counts, FSM states and alpha token width.
package hevc_coeff_pkg;

   localparam int ALPHA_WIDTH = 4;

   localparam logic [3:0] LUMA_TAPS   = 4'd8;
   localparam logic [3:0] CHROMA_TAPS = 4'd4;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Luma rows hold the even fractions only: row n is frac 2n.
   localparam logic signed [7:0] LUMA_TAB [4][8] = '{
      '{ 8'sd0,  8'sd0,  8'sd0,   8'sd64, 8'sd0,   8'sd0,   8'sd0,  8'sd0},
      '{-8'sd1,  8'sd4, -8'sd10,  8'sd58, 8'sd17, -8'sd5,   8'sd1,  8'sd0},
      '{-8'sd1,  8'sd4, -8'sd11,  8'sd40, 8'sd40, -8'sd11,  8'sd4, -8'sd1},
      '{ 8'sd0,  8'sd1, -8'sd5,   8'sd17, 8'sd58, -8'sd10,  8'sd4, -8'sd1}
   };

   localparam logic signed [7:0] CHROMA_TAB [8][4] = '{
      '{ 8'sd0, 8'sd64,  8'sd0,   8'sd0},
      '{-8'sd2, 8'sd58,  8'sd10, -8'sd2},
      '{-8'sd4, 8'sd54,  8'sd16, -8'sd2},
      '{-8'sd6, 8'sd46,  8'sd28, -8'sd4},
      '{-8'sd4, 8'sd36,  8'sd36, -8'sd4},
      '{-8'sd4, 8'sd28,  8'sd46, -8'sd6},
      '{-8'sd2, 8'sd16,  8'sd54, -8'sd4},
      '{-8'sd2, 8'sd10,  8'sd58, -8'sd2}
   };

endpackage

// File: rtl/coeff_interp_serial_if.sv
// Handshake interfaces: read_interface (dout/empty in, read out) for the
// multi-flux alpha source; write_interface (din/write out, full in) for the sink.
interface read_interface #(
   parameter int DW = 5,
   parameter int N  = 2
);
   logic [DW-1:0] dout;
   logic [N-1:0]  empty;
   logic [N-1:0]  read;

   modport actor (
      input  dout,
      input  empty,
      output read
   );
endinterface

interface write_interface #(
   parameter int DW = 10
);
   logic [DW-1:0] din;
   logic          full;
   logic          write;

   modport actor (
      output din,
      output write,
      input  full
   );
endinterface

// File: rtl/coeff_interp_rom.sv
// Combinational tap lookup: chroma, frac, idx -> signed coeff,
// sign-extended from the 8-bit table entries to COEFF_WIDTH.
module coeff_interp_rom
   import hevc_coeff_pkg::*;
#(
   parameter int COEFF_WIDTH = 9
) (
   input  logic                          chroma,
   input  logic [2:0]                    frac,
   input  logic [2:0]                    idx,
   output logic signed [COEFF_WIDTH-1:0] coeff
);

   logic signed [7:0] raw;

   always_comb begin
      raw = '0;
      unique case (1'b1)
         chroma:  raw = CHROMA_TAB[frac][idx[1:0]];
         !chroma: raw = LUMA_TAB[frac[2:1]][idx];
      endcase
   end

   assign coeff = COEFF_WIDTH'(raw);

endmodule

// File: rtl/coeff_interp_serial.sv
// Round-robin pops one alpha token per sequence from FLUX fluxes and streams
// its 8 (luma) or 4 (chroma) taps as {tag,coeff}; ports clk, rst_n, read_port_alpha, write_port_c, err.
module coeff_interp_serial
   import hevc_coeff_pkg::*;
#(
   parameter int FLUX        = 2,
   parameter int COEFF_WIDTH = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   read_interface.actor  read_port_alpha,
   write_interface.actor write_port_c,
   output logic          err
);

   localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;

   state_t                        state;
   state_t                        state_nxt;
   logic [TAG_WIDTH-1:0]          last_grant;
   logic [TAG_WIDTH-1:0]          tag;
   logic [TAG_WIDTH-1:0]          gnt_idx;
   logic                          gnt_vld;
   logic                          chroma;
   logic [2:0]                    frac;
   logic [2:0]                    idx;
   logic [3:0]                    ntap;
   logic [FLUX-1:0]               read_v;
   logic                          wr;
   logic                          last_tap;
   logic                          alpha_chroma;
   logic [2:0]                    alpha_frac;
   logic                          alpha_legal;
   logic signed [COEFF_WIDTH-1:0] coeff;
   logic                          unused_tag;

   // Token tag bits are redundant: the granted index is the tag.
   assign alpha_chroma = read_port_alpha.dout[3];
   assign alpha_frac   = read_port_alpha.dout[2:0];
   assign unused_tag   = ^read_port_alpha.dout[TAG_WIDTH+3:4];
   assign alpha_legal  = alpha_chroma | ~alpha_frac[0];

   assign last_tap = ({1'b0, idx} == (ntap - 4'd1));

   // Scan downward so the lowest offset from last_grant wins.
   always_comb begin
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = FLUX; k >= 1; k--) begin
         j = (int'(last_grant) + k) % FLUX;
         if (!read_port_alpha.empty[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = TAG_WIDTH'(j);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      read_v    = '0;
      wr        = 1'b0;
      unique case (state)
         IDLE: begin
            if (gnt_vld) begin
               read_v[gnt_idx] = 1'b1;
               if (alpha_legal)
                  state_nxt = EMIT;
            end
         end
         EMIT: begin
            wr = ~write_port_c.full;
            if (wr && last_tap)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!rst_n) begin
         read_v = '0;
         wr     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         err        <= 1'b0;
         last_grant <= TAG_WIDTH'(FLUX - 1);
         tag        <= '0;
         chroma     <= 1'b0;
         frac       <= '0;
         ntap       <= LUMA_TAPS;
      end else begin
         state <= state_nxt;
         if (state == IDLE && gnt_vld) begin
            last_grant <= gnt_idx;
            tag        <= gnt_idx;
            chroma     <= alpha_chroma;
            frac       <= alpha_frac;
            idx        <= '0;
            ntap       <= alpha_chroma ? CHROMA_TAPS : LUMA_TAPS;
            if (!alpha_legal)
               err <= 1'b1;
         end
         if (wr)
            idx <= last_tap ? 3'd0 : idx + 3'd1;
      end
   end

   coeff_interp_rom #(
      .COEFF_WIDTH (COEFF_WIDTH)
   ) u_rom (
      .chroma (chroma),
      .frac   (frac),
      .idx    (idx),
      .coeff  (coeff)
   );

   assign read_port_alpha.read = read_v;
   assign write_port_c.write   = wr;
   assign write_port_c.din     = {tag, coeff};

endmodule

// File: tb/tb_coeff_interp_serial.sv
// Bench for coeff_interp_serial (FLUX=4, COEFF_WIDTH=12): directed cases
// plus randomized rounds scored against a token-level reference model.
module tb_coeff_interp_serial;

   localparam int FLUX = 4;
   localparam int CW   = 12;
   localparam int TW   = $clog2(FLUX);

   logic clk = 1'b0;
   logic rst_n;
   logic err;

   int total = 0;
   int bad   = 0;

   int lt [4][8] = '{
      '{ 0, 0,   0, 64,  0,   0, 0,  0},
      '{-1, 4, -10, 58, 17,  -5, 1,  0},
      '{-1, 4, -11, 40, 40, -11, 4, -1},
      '{ 0, 1,  -5, 17, 58, -10, 4, -1}
   };
   int ct [8][4] = '{
      '{ 0, 64,  0,  0}, '{-2, 58, 10, -2},
      '{-4, 54, 16, -2}, '{-6, 46, 28, -4},
      '{-4, 36, 36, -4}, '{-4, 28, 46, -6},
      '{-2, 16, 54, -4}, '{-2, 10, 58, -2}
   };

   logic [3:0] mem [FLUX][64];
   int hd [FLUX];
   int tl [FLUX];

   read_interface  #(.DW(TW + 4), .N(FLUX)) rif ();
   write_interface #(.DW(TW + CW))          wif ();

   coeff_interp_serial #(
      .FLUX        (FLUX),
      .COEFF_WIDTH (CW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .read_port_alpha (rif),
      .write_port_c    (wif),
      .err             (err)
   );

   always #5 clk = ~clk;

   always_comb begin
      rif.empty = '0;
      for (int i = 0; i < FLUX; i++)
         rif.empty[i] = (hd[i] == tl[i]);
   end

   always_comb begin
      rif.dout = '0;
      for (int i = 0; i < FLUX; i++)
         if (rif.read[i])
            rif.dout = {TW'(i), mem[i][hd[i] % 64]};
   end

   always @(posedge clk)
      for (int i = 0; i < FLUX; i++)
         if (rif.read[i])
            hd[i] <= hd[i] + 1;

   task automatic check(string t, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", t, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int f, logic [3:0] a);
      mem[f][tl[f] % 64] = a;
      tl[f] = tl[f] + 1;
   endtask

   function automatic int ed(int tg, int c);
      return (tg << CW) | (c & ((1 << CW) - 1));
   endfunction

   function automatic int tapv(bit ch, int fr, int i);
      return ch ? ct[fr][i] : lt[fr / 2][i];
   endfunction

   function automatic bit drained();
      for (int f = 0; f < FLUX; f++)
         if (hd[f] != tl[f]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic rand_round(int r);
      int q[$];
      int tok [FLUX][8];
      int cnt [FLUX];
      int p   [FLUX];
      int ebad;
      int m_last;
      int left;
      int j;
      int budget;
      logic [3:0] a;
      ebad   = 0;
      m_last = FLUX - 1;
      left   = 0;
      rst_n  = 1'b0;
      wif.full = 1'b0;
      for (int f = 0; f < FLUX; f++) begin
         cnt[f] = $urandom_range(0, 5);
         p[f]   = 0;
         left  += cnt[f];
         for (int k = 0; k < cnt[f]; k++) begin
            a = 4'($urandom_range(0, 15));
            tok[f][k] = int'(a);
            push(f, a);
         end
      end
      while (left > 0) begin
         j = m_last;
         do j = (j + 1) % FLUX; while (p[j] >= cnt[j]);
         a = 4'(tok[j][p[j]]);
         p[j]++;
         left--;
         m_last = j;
         if (!a[3] && a[0])
            ebad = 1;
         else
            for (int i = 0; i < (a[3] ? 4 : 8); i++)
               q.push_back(ed(j, tapv(a[3], int'(a[2:0]), i)));
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      budget = 0;
      while (!(q.size() == 0 && drained()) && budget < 3000) begin
         cyc();
         wif.full = ($urandom_range(0, 3) == 0);
         #1;
         if (wif.write) begin
            if (q.size() == 0)
               check($sformatf("rnd%0d_extra", r), 1, 0);
            else
               check($sformatf("rnd%0d_din", r), int'(wif.din), q.pop_front());
         end
         budget++;
      end
      wif.full = 1'b0;
      check($sformatf("rnd%0d_left", r), q.size(), 0);
      for (int c = 0; c < 10; c++) begin
         cyc();
         #1;
         check($sformatf("rnd%0d_idle_wr", r), int'(wif.write), 0);
      end
      check($sformatf("rnd%0d_err", r), int'(err), ebad);
   endtask

   initial begin
      int g[$];
      int budget;
      for (int f = 0; f < FLUX; f++) begin
         hd[f] = 0;
         tl[f] = 0;
      end
      rst_n    = 1'b0;
      wif.full = 1'b0;

      // reset with tokens waiting: nothing may be popped or written
      push(0, 4'b0100);
      push(0, 4'b0000);
      cyc();
      #1;
      check("rst_read", int'(rif.read), 0);
      check("rst_write", int'(wif.write), 0);
      cyc();
      cyc();
      #1;
      check("rst_err", int'(err), 0);
      check("rst_read2", int'(rif.read), 0);

      // luma f4 on flux 0, then luma f0 granted at cycle 9
      rst_n = 1'b1;
      #1;
      check("l4_read", int'(rif.read), 1);
      for (int i = 0; i < 8; i++) begin
         cyc();
         #1;
         check("l4_wr", int'(wif.write), 1);
         check("l4_din", int'(wif.din), ed(0, lt[2][i]));
         check("l4_noread", int'(rif.read), 0);
      end
      cyc();
      #1;
      check("l4_regrant", int'(rif.read), 1);
      check("l4_gap_wr", int'(wif.write), 0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         #1;
         check("l0_din", int'(wif.din), ed(0, lt[0][i]));
         check("l0_wr", int'(wif.write), 1);
      end
      cyc();
      #1;
      check("l0_done_wr", int'(wif.write), 0);

      // chroma f3 on flux 1 with 3-cycle stall on the first offer
      cyc();
      push(1, 4'b1011);
      #1;
      check("c3_read", int'(rif.read), 2);
      wif.full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check("c3_stall_wr", int'(wif.write), 0);
         check("c3_stall_din", int'(wif.din), ed(1, -6));
      end
      cyc();
      wif.full = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            cyc();
            #1;
         end
         check("c3_wr", int'(wif.write), 1);
         check("c3_din", int'(wif.din), ed(1, ct[3][i]));
      end

      // three tokens on each of flux 0 and 1: alternating grants
      cyc();
      for (int k = 0; k < 3; k++) begin
         push(0, 4'b1000);
         push(1, 4'b1000);
      end
      #1;
      budget = 0;
      while (g.size() < 6 && budget < 200) begin
         for (int f = 0; f < FLUX; f++)
            if (rif.read[f]) g.push_back(f);
         cyc();
         #1;
         budget++;
      end
      check("rr_count", g.size(), 6);
      for (int k = 0; k < 6 && k < g.size(); k++)
         check("rr_order", g[k], k % 2);
      for (int c = 0; c < 6; c++) cyc();

      // odd luma fraction: popped, flagged, nothing emitted
      push(0, 4'b0101);
      #1;
      check("l5_read", int'(rif.read), 1);
      for (int c = 0; c < 4; c++) begin
         cyc();
         #1;
         check("l5_wr", int'(wif.write), 0);
         check("l5_err", int'(err), 1);
      end

      // reset mid-sequence of luma f2
      cyc();
      push(0, 4'b0010);
      #1;
      check("l2_read", int'(rif.read), 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check("l2_din", int'(wif.din), ed(0, lt[1][i]));
      end
      cyc();
      rst_n = 1'b0;
      push(1, 4'b1000);
      push(0, 4'b0010);
      #1;
      check("l2_rst_wr", int'(wif.write), 0);
      check("l2_rst_rd", int'(rif.read), 0);
      cyc();
      #1;
      check("l2_rst_err", int'(err), 0);
      check("l2_rst_wr2", int'(wif.write), 0);
      rst_n = 1'b1;
      #1;
      check("l2_prio", int'(rif.read), 1);
      for (int i = 0; i < 8; i++) begin
         cyc();
         #1;
         check("l2b_wr", int'(wif.write), 1);
         check("l2b_din", int'(wif.din), ed(0, lt[1][i]));
      end
      cyc();
      #1;
      check("l2_next", int'(rif.read), 2);
      for (int c = 0; c < 5; c++) cyc();

      // chroma f1 on flux 3: 12-bit sign extension and 2-bit tag
      push(3, 4'b1001);
      #1;
      check("c1_read", int'(rif.read), 8);
      for (int i = 0; i < 4; i++) begin
         cyc();
         #1;
         check("c1_din", int'(wif.din), ed(3, ct[1][i]));
      end
      check("c1_ext", int'(wif.din), 32'h3FFE);
      cyc();

      for (int r = 0; r < 5; r++)
         rand_round(r);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
